// File: rtl/ps2_ascii_keyboard.sv
// PS/2 set-2 keyboard receiver and decoder: turns make/break frames into a level-held
// ASCII code of the currently pressed key, plus press counting and frame error pulses.
module ps2_ascii_keyboard #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbdata,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic [7:0] press_cnt,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_ONE   = 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchroniser chains idle high, matching the PS/2 bus idle level.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic clk_q, data_q;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) begin
          clk_q  <= 1'b1;
          data_q <= 1'b1;
        end else begin
          clk_q  <= ps2_clk;
          data_q <= ps2_data;
        end
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst) begin
          clk_q  <= 1'b1;
          data_q <= 1'b1;
        end else begin
          clk_q  <= g_sync[gi-1].clk_q;
          data_q <= g_sync[gi-1].data_q;
        end
      end
    end
  end

  logic clk_s, data_s, clk_prev_reg, fall;
  assign clk_s  = g_sync[SYNC_STAGES-1].clk_q;
  assign data_s = g_sync[SYNC_STAGES-1].data_q;
  assign fall   = clk_prev_reg & ~clk_s;

  state_t          state_reg, state_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic            parity_reg, parity_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic            byte_rdy_next, err_next;
  logic            byte_rdy_reg;
  logic [7:0]      byte_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_reg <= 1'b1;
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tmo_reg      <= '0;
      byte_rdy_reg <= 1'b0;
      byte_reg     <= '0;
      frame_err    <= 1'b0;
    end else begin
      clk_prev_reg <= clk_s;
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tmo_reg      <= tmo_next;
      byte_rdy_reg <= byte_rdy_next;
      byte_reg     <= shift_reg;
      frame_err    <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    byte_rdy_next = 1'b0;
    err_next      = 1'b0;
    tmo_next      = (state_reg == IDLE || fall) ? '0 : tmo_reg + TMO_ONE;
    case (state_reg)
      IDLE: if (fall && !data_s) begin
        state_next   = DATA;
        bit_cnt_next = '0;
      end
      DATA: if (fall) begin
        shift_next   = {data_s, shift_reg[7:1]};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) state_next = PARITY;
      end
      PARITY: if (fall) begin
        parity_next = data_s;
        state_next  = STOP;
      end
      STOP: if (fall) begin
        state_next = IDLE;
        if (data_s && ^{shift_reg, parity_reg}) byte_rdy_next = 1'b1;
        else                                    err_next      = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // A stalled frame is abandoned so the next start bit is seen cleanly.
    if (state_reg != IDLE && tmo_reg == TMO_LIMIT) begin
      state_next    = IDLE;
      err_next      = 1'b1;
      byte_rdy_next = 1'b0;
      tmo_next      = '0;
    end
  end

  function automatic logic [7:0] ascii_map(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h41; 8'h32: return 8'h42; 8'h21: return 8'h43; 8'h23: return 8'h44;
      8'h24: return 8'h45; 8'h2B: return 8'h46; 8'h34: return 8'h47; 8'h33: return 8'h48;
      8'h43: return 8'h49; 8'h3B: return 8'h4A; 8'h42: return 8'h4B; 8'h4B: return 8'h4C;
      8'h3A: return 8'h4D; 8'h31: return 8'h4E; 8'h44: return 8'h4F; 8'h4D: return 8'h50;
      8'h15: return 8'h51; 8'h2D: return 8'h52; 8'h1B: return 8'h53; 8'h2C: return 8'h54;
      8'h3C: return 8'h55; 8'h2A: return 8'h56; 8'h1D: return 8'h57; 8'h22: return 8'h58;
      8'h35: return 8'h59; 8'h1A: return 8'h5A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      8'h29: return 8'h20; 8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  logic       brk_reg, ext_reg;
  logic [7:0] held_reg;
  logic [7:0] mapped;
  assign mapped = ascii_map(byte_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      brk_reg   <= 1'b0;
      ext_reg   <= 1'b0;
      held_reg  <= '0;
      kbdata    <= '0;
      scan_code <= '0;
      key_valid <= 1'b0;
      press_cnt <= '0;
    end else begin
      key_valid <= 1'b0;
      if (byte_rdy_reg) begin
        if (byte_reg == 8'hF0) begin
          brk_reg <= 1'b1;
        end else if (byte_reg == 8'hE0) begin
          ext_reg <= 1'b1;
        end else if (brk_reg) begin
          // Only releasing the key that currently owns kbdata clears it.
          if (!ext_reg && byte_reg == held_reg) begin
            kbdata   <= '0;
            held_reg <= '0;
          end
          brk_reg <= 1'b0;
          ext_reg <= 1'b0;
        end else if (ext_reg) begin
          ext_reg <= 1'b0;
        end else begin
          scan_code <= byte_reg;
          if (byte_reg != held_reg) begin
            held_reg <= byte_reg;
            kbdata   <= mapped;
            if (mapped != 8'h00) begin
              key_valid <= 1'b1;
              press_cnt <= press_cnt + 8'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_ascii_keyboard.sv
// Self-checking bench: drives PS/2 frames (directed and random) and compares the
// decoder outputs against a byte-level behavioural model of the key rules.
module tb_ps2_ascii_keyboard;

  localparam int TMO = 200;
  localparam int H   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kbdata, scan_code, press_cnt;
  logic       key_valid, frame_err;

  ps2_ascii_keyboard #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbdata(kbdata), .scan_code(scan_code), .key_valid(key_valid),
    .press_cnt(press_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int kv_seen = 0, err_seen = 0, both_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      kv_seen  += int'(key_valid);
      err_seen += int'(frame_err);
      if (key_valid && frame_err) both_seen++;
    end
  end

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46};

  function automatic logic [7:0] ascii_of(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (letter_codes[i] == c) return 8'h41 + i[7:0];
    for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return 8'h30 + i[7:0];
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  function automatic logic [7:0] mapped_code(input int k);
    if (k < 26) return letter_codes[k];
    if (k < 36) return digit_codes[k-26];
    return (k == 36) ? 8'h29 : 8'h5A;
  endfunction

  // Behavioural model of what the keyboard should present after each accepted byte.
  logic [7:0] m_kb = 0, m_scan = 0, m_held = 0, m_press = 0;
  bit         m_brk = 0, m_ext = 0;
  int         m_kv = 0, m_err = 0;

  task automatic model_reset();
    m_kb = 0; m_scan = 0; m_held = 0; m_press = 0; m_brk = 0; m_ext = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk) begin
      if (!m_ext && b == m_held) begin m_kb = 0; m_held = 0; end
      m_brk = 0; m_ext = 0;
    end else if (m_ext) m_ext = 0;
    else begin
      m_scan = b;
      if (b != m_held) begin
        m_held = b;
        m_kb   = ascii_of(b);
        if (m_kb != 0) begin m_kv++; m_press++; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".kbdata"}, kbdata, m_kb);
    chk({tag, ".press_cnt"}, press_cnt, m_press);
    chk({tag, ".scan_code"}, scan_code, m_scan);
    chk({tag, ".key_valid_pulses"}, kv_seen, m_kv);
    chk({tag, ".frame_err_pulses"}, err_seen, m_err);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    send_bits(bits, 11);
    repeat (8) @(negedge clk);
    if (bad) m_err++;
    else model_byte(b);
  endtask

  initial begin
    logic [7:0] b;
    int sel;
    repeat (4) @(negedge clk);
    chk("reset.kbdata", kbdata, 0);
    chk("reset.scan_code", scan_code, 0);
    chk("reset.key_valid", key_valid, 0);
    chk("reset.press_cnt", press_cnt, 0);
    chk("reset.frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(8'h1C, 0); chk_all("make_A");
    chk("make_A.ascii", kbdata, 8'h41);
    send_frame(8'h1C, 0); send_frame(8'h1C, 0); chk_all("typematic");
    chk("typematic.press_cnt", press_cnt, 1);
    send_frame(8'hF0, 0); send_frame(8'h1C, 0); chk_all("release_A");

    send_frame(8'h16, 0); chk_all("make_1");
    send_frame(8'h1E, 0); chk_all("make_2");
    send_frame(8'hF0, 0); send_frame(8'h16, 0); chk_all("release_old");
    chk("release_old.ascii", kbdata, 8'h32);
    send_frame(8'hF0, 0); send_frame(8'h1E, 0); chk_all("release_2");

    send_frame(8'h2D, 1); chk_all("bad_parity");

    send_bits(11'h07A, 6);
    repeat (TMO + 20) @(negedge clk);
    m_err++;
    chk_all("timeout");
    send_frame(8'h29, 0); chk_all("after_timeout");
    chk("after_timeout.ascii", kbdata, 8'h20);
    send_frame(8'hF0, 0); send_frame(8'h29, 0);
    send_frame(8'hE0, 0); send_frame(8'h75, 0); chk_all("ext_make");
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0); chk_all("ext_break");

    send_frame(8'h24, 0); chk_all("make_E");
    send_bits(11'h049, 5);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    chk("midreset.kbdata", kbdata, 0);
    chk("midreset.press_cnt", press_cnt, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      b = mapped_code(i % 38);
      send_frame(b, 0);
      send_frame(8'hF0, 0);
      send_frame(b, 0);
      if (i % 64 == 63) chk_all("wrap_progress");
    end
    chk("wrap.press_cnt", press_cnt, 0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      send_frame(mapped_code(int'($urandom_range(0, 37))), 0);
      else if (sel == 6) send_frame(8'hF0, 0);
      else if (sel == 7) send_frame(8'hE0, 0);
      else if (sel == 8) send_frame(8'($urandom_range(0, 255)), 0);
      else               send_frame(8'($urandom_range(0, 255)), 1);
      chk_all("random");
    end
    chk("kv_err_overlap", both_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
